bcd_down_counter: RTL
=====================

# bcd_down_counter

Synchronous, loadable, multi-digit BCD down counter with a small run/idle controller, a zero flag and a terminal-count pulse. It counts in the opposite direction to the team's BCD up counters. It serves as the countdown/timer element for display and timing exercises and is driven by an external tick (`en`) rather than the raw clock. All digits update on the same clock edge; there is no ripple clocking.

## Interface
- `DIGITS`, default 2: number of BCD digits; legal range 1–4.
- `WRAP`, default 0: 0 = stop at zero and return to IDLE; 1 = wrap from all-zeros to all-nines and keep running.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserting it clears all state immediately, and release is synchronous to `clk`.
- `load`  in  1  synchronous load strobe for `load_val`.
- `load_val`  in  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i].
- `start`  in  1  request to begin counting.
- `stop`  in  1  request to halt counting; the count is held.
- `en`  in  1  count tick; decrements only in RUN.
- `Q`  out  4*DIGITS  current BCD count, registered.
- `zero`  out  1  high when `Q` is all zeros, registered.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on terminal count.

## Operation
- FSM states:
  - IDLE: count held.
  - RUN: count decrements on each `en`.
- Priority within a cycle: `load` > `stop` > `start` > `en`.
- `load`:
  - Q <= load_val; the FSM state is unchanged.
  - Any digit of `load_val` above 9 is clamped to 9 per digit (e.g. 4'hC → 9).
- `stop`: in RUN, go to IDLE with Q held. In IDLE it has no effect.
- `start`:
  - In IDLE with Q ≠ 0, go to RUN.
  - In IDLE with Q = 0 and WRAP=0, `done` pulses the next cycle and the FSM stays in IDLE.
  - In IDLE with Q = 0 and WRAP=1, go to RUN.
  - `start` is ignored in RUN.
- Decrement (RUN and `en`):
  - Digit 0 always receives a borrow-in.
  - A digit at 0 with borrow-in becomes 9 and borrows from the next digit.
  - Otherwise the digit decrements by 1 and borrowing stops there.
- Terminal, WRAP=0: when Q = 0…01 and `en` is high in RUN, Q becomes 0, `done` pulses and the FSM goes to IDLE. A further `en` in IDLE has no effect.
- Terminal, WRAP=1: when Q = 0 and `en` is high in RUN, Q becomes all nines, `done` pulses and the FSM stays in RUN.
- `load` in RUN: the new value takes effect and counting continues from it.
  - If the loaded value is 0 and WRAP=0, go to IDLE without a `done` pulse.
- `en` while `load` or `stop` is active: the `en` is ignored in that cycle.
- Reset (asynchronous, any time including mid-count):
  - Q = 0, `zero` = 1, `busy` = 0, `done` = 0, FSM = IDLE.

## Timing
- Every output is registered. `Q`, `zero` and `busy` change one clock after the sampled input.
- Latency from an `en` edge to the new `Q` is 1 cycle.
- `done` is asserted in the same cycle that `Q` first shows the terminal value (0, or all nines for WRAP=1). It is high for exactly one cycle.
- `zero` is always consistent with `Q` in the same cycle.
- Back-to-back `en`, one per cycle, gives one decrement per cycle, with no gaps and no lost ticks.

## Structure
Shared package `bcd_pkg` holds:
- `bcd_t` = logic [3:0]
- `BCD_MAX` = 4'd9
- the `state_t` enum {IDLE, RUN}
- the clamp function `bcd_clamp`

Natural sub-module `bcd_digit_down`: one digit register with `load`, `load_d`, borrow-in and borrow-out. `bcd_down_counter` instantiates it DIGITS times through a generate loop, and the top level adds the FSM and flag logic.

## Test plan
- Reset then idle: hold `rst`=0 for 2 cycles, then release → Q=00, `zero`=1, `busy`=0, `done`=0. Then assert `rst`=0 in the middle of a RUN at Q=37 → Q goes to 00 immediately, without waiting for a clock edge.
- Full countdown, WRAP=0: load 12, start, then `en` every cycle → Q goes 11, 10, 09, …, 01, 00. `done` is high only in the cycle Q=00, `busy` falls with it, and extra `en` pulses leave Q at 00.
- Borrow chain, DIGITS=3: load 100, start, one `en` → Q=099. Then load 4'hA in every digit → Q=999 (clamped).
- Wrap, WRAP=1: load 01, start, then 3 `en` → Q goes 00 (`done` pulse), 99 (`done` pulse), 98, and `busy` stays 1 throughout.
- Priority and pause: in RUN at Q=50, assert `stop` and `en` together → Q=50 and IDLE. Assert `start` → RUN resumes. Assert `load`=25 with `en` → Q=25, not 24.
- Start at zero, WRAP=0: with Q=00, pulse `start` → `done` pulses one cycle later, `busy` stays 0 and Q stays 00.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types, limits and helpers for the BCD counter family.
// Digits are 4-bit BCD codes. Values above 9 are clamped on entry.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Saturate a non-decimal nibble (A..F) to 9 so the counter never holds an illegal code.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down counter: parallel load, borrow-in decrement, borrow-out.
// The digit exposes its next value so the parent can register flags that match Q.
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  bcd_t load_d_i,
  input  logic borrow_i,
  output logic borrow_o,
  output bcd_t q_o,
  output bcd_t q_d_o
);

  bcd_t q_q;
  bcd_t q_d;

  // NOTE: always_comb assigns a default first so no path leaves q_d unassigned (no latch).
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = bcd_clamp(load_d_i);
    end else if (borrow_i) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all digits update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign borrow_o = borrow_i & (q_q == 4'd0);
  assign q_o      = q_q;
  assign q_d_o    = q_d;

endmodule

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD down counter with IDLE/RUN control, zero flag and
// a one-cycle terminal-count pulse. Counting is gated by the en tick.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int WRAP   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                stop,
  input  logic                en,
  output logic [4*DIGITS-1:0] Q,
  output logic                zero,
  output logic                busy,
  output logic                done
);

  localparam int           W       = 4 * DIGITS;
  localparam logic [W-1:0] ONE     = W'(1);
  localparam bit           WRAP_EN = (WRAP != 0);

  // Assertion of rst clears everything at once; release is retimed to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_t        state_q, state_d;
  logic          busy_q, zero_q, done_q;
  logic          done_d;
  logic          run, dec, q_is_zero, q_is_one;
  logic [W-1:0]  q_next;
  logic [DIGITS:0] borrow;

  assign run       = (state_q == RUN);
  assign q_is_zero = (Q == '0);
  assign q_is_one  = (Q == ONE);

  // Without wrap, RUN never legitimately sits at zero; the guard keeps it from rolling to nines.
  assign dec       = run & en & ~load & ~stop & (WRAP_EN | ~q_is_zero);
  assign borrow[0] = dec;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_down u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load),
      .load_d_i (load_val[4*i +: 4]),
      .borrow_i (borrow[i]),
      .borrow_o (borrow[i+1]),
      .q_o      (Q[4*i +: 4]),
      .q_d_o    (q_next[4*i +: 4])
    );
  end

  // borrow[DIGITS] fires only when the whole count wraps from zero to all nines.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (load) begin
      if (run && (load_val == '0) && !WRAP_EN) begin
        state_d = IDLE;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (!run) begin
      if (start) begin
        if (!q_is_zero || WRAP_EN) begin
          state_d = RUN;
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (dec) begin
      done_d = q_is_one | borrow[DIGITS];
      if (q_is_one && !WRAP_EN) begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: every control register has an explicit reset value; zero resets high to match Q=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      zero_q  <= (q_next == '0);
      done_q  <= done_d;
    end
  end

  assign zero = zero_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
